// File: rtl/dcache_pkg.sv
// Shared types and address-field helpers for the direct-mapped fill cache.
package dcache_pkg;

  typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

  localparam int unsigned ADDR_W_DEF         = 32;
  localparam int unsigned NUM_LINES_DEF      = 4;
  localparam int unsigned WORDS_PER_LINE_DEF = 16;
  localparam int unsigned OFF_W = $clog2(WORDS_PER_LINE_DEF) + 2;
  localparam int unsigned IDX_W = $clog2(NUM_LINES_DEF);
  localparam int unsigned TAG_W = ADDR_W_DEF - OFF_W - IDX_W;

  // Helpers work on a zero-extended address so any ADDR_W up to 64 fits.
  function automatic logic [63:0] get_word(input logic [63:0] a, input int unsigned off_w);
    return (a >> 2) & ((64'd1 << (off_w - 2)) - 64'd1);
  endfunction

  function automatic logic [63:0] get_idx(input logic [63:0] a, input int unsigned off_w,
                                          input int unsigned idx_w);
    return (a >> off_w) & ((64'd1 << idx_w) - 64'd1);
  endfunction

  function automatic logic [63:0] get_tag(input logic [63:0] a, input int unsigned off_w,
                                          input int unsigned idx_w);
    return a >> (off_w + idx_w);
  endfunction

endpackage

// File: rtl/dcache_dm_fill_if.sv
// CPU-side and memory-side signals of the data cache, bundled as one interface.
interface dcache_dm_fill_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              RE;
  logic              WE;
  logic [ADDR_W-1:0] A;
  logic [DATA_W-1:0] WD;
  logic [DATA_W-1:0] RD;
  logic              Ready;
  logic              MemRE;
  logic [ADDR_W-1:0] MemRA;
  logic [DATA_W-1:0] MemRD;
  logic              MemRValid;
  logic              MemWE;
  logic [ADDR_W-1:0] MemWA;
  logic [DATA_W-1:0] MemWD;
  logic              MemWAck;

  modport slave (
    input  RE, WE, A, WD, MemRD, MemRValid, MemWAck,
    output RD, Ready, MemRE, MemRA, MemWE, MemWA, MemWD
  );

  modport master (
    output RE, WE, A, WD, MemRD, MemRValid, MemWAck,
    input  RD, Ready, MemRE, MemRA, MemWE, MemWA, MemWD
  );
endinterface

// File: rtl/dcache_fill_fsm.sv
// Cache control FSM: owns state, the fill word counter and the memory handshakes.
module dcache_fill_fsm
  import dcache_pkg::*;
#(
  parameter int unsigned WORDS_PER_LINE = 16,
  parameter int unsigned CNT_W          = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             re,
  input  logic             we,
  input  logic             hit,
  input  logic             mem_rvalid,
  input  logic             mem_wack,
  output state_t           state,
  output logic [CNT_W-1:0] cnt,
  output logic             fill_start,
  output logic             fill_beat,
  output logic             fill_done,
  output logic             wr_start,
  output logic             ready,
  output logic             mem_re,
  output logic             mem_we
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WORDS_PER_LINE - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    fill_start = 1'b0;
    fill_beat  = 1'b0;
    fill_done  = 1'b0;
    wr_start   = 1'b0;
    ready      = 1'b0;
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (we) begin
          wr_start = 1'b1;
          state_d  = WRITE;
        end else if (re && !hit) begin
          fill_start = 1'b1;
          cnt_d      = '0;
          state_d    = FILL;
        end else begin
          ready = 1'b1;
        end
      end
      FILL: begin
        mem_re = 1'b1;
        if (mem_rvalid) begin
          fill_beat = 1'b1;
          cnt_d     = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            fill_done = 1'b1;
            state_d   = IDLE;
          end
        end
      end
      WRITE: begin
        mem_we = 1'b1;
        if (mem_wack) begin
          ready   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign state = state_q;
  assign cnt   = cnt_q;
endmodule

// File: rtl/dcache_dm_fill.sv
// Direct-mapped, write-through, no-allocate data cache with a handshaked line fill.
module dcache_dm_fill
  import dcache_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned NUM_LINES      = 4,
  parameter int unsigned WORDS_PER_LINE = 16
) (
  input logic             CLK,
  input logic             RST,
  dcache_dm_fill_if.slave bus
);
  localparam int unsigned WRD_B = $clog2(WORDS_PER_LINE);
  localparam int unsigned IDX_B = $clog2(NUM_LINES);
  localparam int unsigned OFF_B = WRD_B + 2;
  localparam int unsigned TAG_B = ADDR_W - OFF_B - IDX_B;
  // A single-line cache still needs a 1-bit index signal; it is always 0.
  localparam int unsigned IDX_S = (IDX_B == 0) ? 1 : IDX_B;
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((64'd1 << OFF_B) - 64'd1);

  logic [DATA_W-1:0] data_q [NUM_LINES][WORDS_PER_LINE];
  logic [TAG_B-1:0]  tag_q  [NUM_LINES];
  logic [NUM_LINES-1:0] valid_q, valid_d;
  logic [ADDR_W-1:0] base_q, base_d, mem_wa_q, mem_wa_d;
  logic [DATA_W-1:0] mem_wd_q, mem_wd_d;

  logic [TAG_B-1:0] a_tag, f_tag;
  logic [IDX_S-1:0] a_idx, f_idx;
  logic [WRD_B-1:0] a_word;
  logic             hit;

  state_t           state;
  logic [WRD_B-1:0] cnt;
  logic fill_start, fill_beat, fill_done, wr_start, ready, mem_re, mem_we;

  logic              dwe;
  logic [IDX_S-1:0]  dline;
  logic [WRD_B-1:0]  dword;
  logic [DATA_W-1:0] ddata;

  always_comb begin
    a_tag  = TAG_B'(get_tag(64'(bus.A), OFF_B, IDX_B));
    a_idx  = IDX_S'(get_idx(64'(bus.A), OFF_B, IDX_B));
    a_word = WRD_B'(get_word(64'(bus.A), OFF_B));
    f_tag  = TAG_B'(get_tag(64'(base_q), OFF_B, IDX_B));
    f_idx  = IDX_S'(get_idx(64'(base_q), OFF_B, IDX_B));
    hit    = valid_q[a_idx] && (tag_q[a_idx] == a_tag);
  end

  dcache_fill_fsm #(
    .WORDS_PER_LINE(WORDS_PER_LINE),
    .CNT_W         (WRD_B)
  ) u_fsm (
    .clk       (CLK),
    .rst       (RST),
    .re        (bus.RE),
    .we        (bus.WE),
    .hit       (hit),
    .mem_rvalid(bus.MemRValid),
    .mem_wack  (bus.MemWAck),
    .state     (state),
    .cnt       (cnt),
    .fill_start(fill_start),
    .fill_beat (fill_beat),
    .fill_done (fill_done),
    .wr_start  (wr_start),
    .ready     (ready),
    .mem_re    (mem_re),
    .mem_we    (mem_we)
  );

  // Valid is dropped at fill start so a half-filled line never hits.
  always_comb begin
    valid_d  = valid_q;
    base_d   = base_q;
    mem_wa_d = mem_wa_q;
    mem_wd_d = mem_wd_q;
    dwe      = 1'b0;
    dline    = a_idx;
    dword    = a_word;
    ddata    = bus.WD;
    if (fill_start) begin
      valid_d[a_idx] = 1'b0;
      base_d         = bus.A & ~OFF_MASK;
    end
    if (fill_done) valid_d[f_idx] = 1'b1;
    if (fill_beat) begin
      dwe   = 1'b1;
      dline = f_idx;
      dword = cnt;
      ddata = bus.MemRD;
    end else if (wr_start && hit) begin
      dwe = 1'b1;
    end
    if (wr_start) begin
      mem_wa_d = bus.A;
      mem_wd_d = bus.WD;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      valid_q  <= '0;
      base_q   <= '0;
      mem_wa_q <= '0;
      mem_wd_q <= '0;
    end else begin
      valid_q  <= valid_d;
      base_q   <= base_d;
      mem_wa_q <= mem_wa_d;
      mem_wd_q <= mem_wd_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (dwe) data_q[dline][dword] <= ddata;
    if (fill_done) tag_q[f_idx] <= f_tag;
  end

  assign bus.Ready = ready;
  assign bus.RD    = (state == IDLE && ready && bus.RE && !bus.WE) ? data_q[a_idx][a_word] : '0;
  assign bus.MemRE = mem_re;
  assign bus.MemRA = base_q | (ADDR_W'(cnt) << 2);
  assign bus.MemWE = mem_we;
  assign bus.MemWA = mem_wa_q;
  assign bus.MemWD = mem_wd_q;
endmodule

// File: tb/tb_dcache_dm_fill.sv
// Directed scoreboard bench for dcache_dm_fill: fills, hits, conflicts, stores, reset abort.
module tb_dcache_dm_fill;
  localparam int unsigned WPL = 16;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  logic CLK = 1'b0;
  logic RST;
  int unsigned total  = 0;
  int unsigned passed = 0;

  logic [31:0] rd_q [$];
  logic [31:0] ra_q [$];
  wr_t         wr_q [$];

  dcache_dm_fill_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  dcache_dm_fill #(
    .ADDR_W        (32),
    .DATA_W        (32),
    .NUM_LINES     (4),
    .WORDS_PER_LINE(WPL)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1000 + ((a >> 2) & 32'hF) + (((a >> 6) - 32'd1) << 16);
  endfunction

  assign bus.MemRValid = bus.MemRE;
  assign bus.MemRD     = mem_word(bus.MemRA);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Starts and ends one cycle phase: #1 after a rising edge.
  task automatic do_read(input logic [31:0] addr, input logic [31:0] exp_d,
                         input int unsigned exp_stall);
    int unsigned stalls = 0;
    logic        done   = 1'b0;
    logic [31:0] exp_ra;
    rd_q.push_back(exp_d);
    if (exp_stall != 0)
      for (int unsigned i = 0; i < WPL; i++) ra_q.push_back((addr & ~32'h3F) + 32'(4 * i));
    bus.A  = addr;
    bus.RE = 1'b1;
    bus.WE = 1'b0;
    for (int unsigned c = 0; c < 100 && !done; c++) begin
      @(negedge CLK);
      if (bus.Ready) begin
        chk("rd_data", bus.RD, rd_q.pop_front());
        chk("rd_stall", 32'(stalls), 32'(exp_stall));
        done = 1'b1;
      end else begin
        stalls++;
        if (bus.MemRE && bus.MemRValid) begin
          exp_ra = (ra_q.size() != 0) ? ra_q.pop_front() : 32'hFFFF_FFFF;
          chk("mem_ra", bus.MemRA, exp_ra);
        end
      end
    end
    chk("rd_done", 32'(done), 32'd1);
    chk("ra_left", 32'(ra_q.size()), 32'd0);
    rd_q.delete();
    ra_q.delete();
    @(posedge CLK);
    #1 bus.RE = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input int unsigned nack, input logic also_re);
    int unsigned we_cyc = 0;
    logic        done   = 1'b0;
    wr_t         cur    = '0;
    wr_q.push_back({addr, data});
    bus.A  = addr;
    bus.WD = data;
    bus.WE = 1'b1;
    bus.RE = also_re;
    for (int unsigned c = 0; c < 100 && !done; c++) begin
      @(negedge CLK);
      chk("no_memre", 32'(bus.MemRE), 32'd0);
      if (bus.MemWE) begin
        if (we_cyc == 0) cur = wr_q.pop_front();
        we_cyc++;
        chk("mem_wa", bus.MemWA, cur.a);
        chk("mem_wd", bus.MemWD, cur.d);
        if (we_cyc == nack) begin
          bus.MemWAck = 1'b1;
          #1 chk("wr_ack_ready", 32'(bus.Ready), 32'd1);
          done = 1'b1;
        end else begin
          chk("wr_wait_ready", 32'(bus.Ready), 32'd0);
        end
      end else begin
        chk("wr_issue_ready", 32'(bus.Ready), 32'd0);
      end
    end
    chk("wr_done", 32'(done), 32'd1);
    wr_q.delete();
    @(posedge CLK);
    #1;
    bus.MemWAck = 1'b0;
    bus.WE      = 1'b0;
    bus.RE      = 1'b0;
    @(negedge CLK);
    chk("memwe_drop", 32'(bus.MemWE), 32'd0);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST         = 1'b1;
    bus.RE      = 1'b0;
    bus.WE      = 1'b0;
    bus.A       = '0;
    bus.WD      = '0;
    bus.MemWAck = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_ready", 32'(bus.Ready), 32'd1);
    chk("rst_memre", 32'(bus.MemRE), 32'd0);
    chk("rst_memwe", 32'(bus.MemWE), 32'd0);
    chk("rst_memra", bus.MemRA, 32'd0);
    chk("rst_memwa", bus.MemWA, 32'd0);
    chk("rst_memwd", bus.MemWD, 32'd0);
    chk("rst_rd", bus.RD, 32'd0);
    RST = 1'b0;
    @(posedge CLK);
    #1;

    do_read(32'h40,  32'h1000, 17);
    do_read(32'h44,  32'h1001, 0);
    do_read(32'h140, 32'h41000, 17);
    do_read(32'h40,  32'h1000, 17);
    do_write(32'h48, 32'hDEADBEEF, 3, 1'b0);
    do_read(32'h48,  32'hDEADBEEF, 0);
    do_write(32'h200, 32'hCAFEF00D, 2, 1'b0);
    do_read(32'h200, 32'h71000, 17);

    // Abort a fill of 0x140 after five beats.
    bus.A  = 32'h140;
    bus.RE = 1'b1;
    repeat (6) @(posedge CLK);
    #1 chk("mid_fill_ra", bus.MemRA, 32'h154);
    RST    = 1'b1;
    bus.RE = 1'b0;
    #1;
    chk("abort_memre", 32'(bus.MemRE), 32'd0);
    chk("abort_ready", 32'(bus.Ready), 32'd1);
    chk("abort_memra", bus.MemRA, 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK);
    #1;
    do_read(32'h40, 32'h1000, 17);

    do_write(32'h40, 32'h12345678, 1, 1'b1);
    do_read(32'h40, 32'h12345678, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/dcache_dm_fill.md
Name: dcache_dm_fill

Overview:
- Parametrised direct-mapped data cache between the MEM stage and main data memory.
- Generalises the single-line, 16-word cache: NUM_LINES lines of WORDS_PER_LINE words each, with explicit per-line valid bits replacing X-detection.
- Adds a handshaked line-fill FSM for read misses and a write-through, no-allocate store path.
- Presents a stall signal (Ready) to the pipeline.

Parameters:
- ADDR_W, 32, byte address width.
- DATA_W, 32, word width. Fixed at 32; byte offset is 2 bits.
- NUM_LINES, 4, number of lines. Power of 2, at least 1.
- WORDS_PER_LINE, 16, words per line. Power of 2, at least 2.

Ports:
- CLK  in  1  clock.
- RST  in  1  asynchronous active-high reset.
- RE  in  1  CPU load request.
- WE  in  1  CPU store request.
- A  in  ADDR_W  CPU byte address. Word-aligned.
- WD  in  DATA_W  CPU store data.
- RD  out  DATA_W  load data. Valid when Ready&RE.
- Ready  out  1  request completes this cycle. Pipeline stalls while 0.
- MemRE  out  1  memory word-read request.
- MemRA  out  ADDR_W  memory read address.
- MemRD  in  DATA_W  memory read data.
- MemRValid  in  1  MemRD valid for the current MemRA.
- MemWE  out  1  memory write request.
- MemWA  out  ADDR_W  memory write address.
- MemWD  out  DATA_W  memory write data.
- MemWAck  in  1  memory accepted the write.

Behaviour:
- Address split:
  - OFF = log2(WORDS_PER_LINE) + 2.
  - word = A[OFF-1:2].
  - index = A[OFF+log2(NUM_LINES)-1:OFF].
  - tag = the remaining upper bits.
- Storage: data array, tag array, valid vector.
- Reset (async, RST=1):
  - valid cleared, FSM to IDLE.
  - MemRE, MemWE = 0; MemRA, MemWA, MemWD = 0.
  - RD = 0; Ready = 1 (no request pending).
  - Data and tag arrays are not reset.
- Hit = valid[index] & tag match.
- IDLE state:
  - RE&~WE&Hit: Ready=1 combinationally, RD = data[index][word]. Zero-cycle latency.
  - RE&~WE&~Hit: Ready=0. Latch line base = {tag,index,0}, clear word counter, go FILL.
  - WE (RE ignored; WE has priority):
    - Ready=0.
    - If Hit, update data[index][word] <= WD at this edge.
    - Latch A/WD into MemWA/MemWD, go WRITE.
  - No request: Ready=1, RD=0.
- FILL state:
  - MemRE=1, MemRA = base + 4*cnt.
  - On each MemRValid: write MemRD into data[index][cnt], cnt++.
  - On the last word (cnt==WORDS_PER_LINE-1 & MemRValid): write tag, set valid[index], go IDLE.
  - Ready=0 throughout.
  - valid[index] is cleared at fill start, so a partially filled line is never a hit.
- WRITE state:
  - MemWE=1 holding MemWA/MemWD.
  - On MemWAck: MemWE drops next cycle, go IDLE. Ready=1 in the ack cycle.
  - A store miss does not allocate.
- Total latency:
  - Read miss = WORDS_PER_LINE MemRValid beats + 1 cycle; the hit completes in IDLE.
  - Store = cycles until MemWAck.
- CPU inputs are sampled only in IDLE; A/RE/WE must be held stable while Ready=0.
- Reset mid-FILL or mid-WRITE aborts the transfer immediately. The partial line stays invalid; the write is lost.
- Line replacement is unconditional overwrite (direct-mapped, write-through, so no dirty state).
- Counter width is log2(WORDS_PER_LINE). Wrap-around at the end of a fill is prevented by the state exit.

Decomposition:
- Shared package dcache_pkg holds:
  - state enum (IDLE, FILL, WRITE).
  - localparams derived from the parameters: OFF_W, IDX_W, TAG_W.
  - field-extract functions get_tag, get_idx, get_word.
- One natural sub-module, dcache_fill_fsm: owns state, the word counter, and the MemRE/MemWE handshakes.
- Arrays and hit logic stay in the top module.

Test Plan:
- Cold read: RST pulse, then RE, A=0x40 with memory returning 0x1000+i for word i (1-cycle MemRValid) → Ready=0 for 17 cycles, MemRA sweeps 0x40..0x7C, then RD=0x1000, Ready=1. A second RE at 0x44 gives RD=0x1001 with zero stall.
- Conflict miss: after the fill above, RE at A=0x140 (same index 1, new tag) → refill from 0x140. A subsequent RE at 0x40 misses again.
- Store hit: line 0x40 resident; WE, A=0x48, WD=0xDEADBEEF, MemWAck after 3 cycles → MemWE/MemWA=0x48/MemWD held 3 cycles. A following RE at 0x48 returns 0xDEADBEEF with no refill.
- Store miss: WE at A=0x200 → memory write issued; a following RE at 0x200 misses (no allocate).
- Reset mid-fill: RST asserted after 5 of 16 beats → MemRE=0 immediately, Ready=1. RE at 0x40 then restarts a full 16-beat fill at 0x40.
- Simultaneous RE&WE at 0x40 → treated as a store only, and no MemRE is issued.
